// File: rtl/tx_port_scheduler.sv
// tx_port_scheduler: arbitrates the SOF, send-packet and direct-control requesters onto one TX port,
// with a hold limit, post-release idle gap and a lockout for requesters that hit the limit.
module tx_port_scheduler #(
  parameter int HOLD_MAX   = 255,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sofReq,
  input  logic       sendPacketReq,
  input  logic       directCntlReq,
  input  logic       sofWEn,
  input  logic       sendPacketWEn,
  input  logic       directCntlWEn,
  input  logic [7:0] sofData,
  input  logic [7:0] sendPacketData,
  input  logic [7:0] directCntlData,
  input  logic [7:0] sofCntl,
  input  logic [7:0] sendPacketCntl,
  input  logic [7:0] directCntlCntl,
  output logic       sofGnt,
  output logic       sendPacketGnt,
  output logic       directCntlGnt,
  input  logic       txPortRdyIn,
  output logic       txPortRdyOut,
  output logic       txPortWEnable,
  output logic [7:0] txPortData,
  output logic [7:0] txPortCntl,
  output logic       timeoutErr,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, GNT_SOF, GNT_SP, GNT_DC, GAP} state_t;
  state_t state, nextState;
  logic [15:0] holdCnt;
  logic [3:0] gapCnt;
  logic [2:0] req, elig, lock, gnt, nextGnt;
  logic rrLastDc, curReq, timeout;
  assign req = {directCntlReq, sendPacketReq, sofReq};
  assign elig = req & ~lock;
  assign curReq = |(req & gnt);
  always_comb begin
    nextState = state;
    timeout = 1'b0;
    case (state)
      IDLE: nextState = elig[0] ? GNT_SOF :
                        (elig[1] && elig[2]) ? (rrLastDc ? GNT_SP : GNT_DC) :
                        elig[1] ? GNT_SP :
                        elig[2] ? GNT_DC : IDLE;
      GNT_SOF, GNT_SP, GNT_DC:
        if (!curReq || holdCnt == 16'(HOLD_MAX - 1)) begin
          timeout = curReq;
          nextState = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      GAP: nextState = (gapCnt == 4'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default: nextState = IDLE;
    endcase
    nextGnt = {nextState == GNT_DC, nextState == GNT_SP, nextState == GNT_SOF};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      holdCnt <= '0;
      gapCnt <= '0;
      lock <= '0;
      rrLastDc <= 1'b1;
      timeoutErr <= 1'b0;
    end else begin
      state <= nextState;
      gnt <= nextGnt;
      timeoutErr <= timeout;
      holdCnt <= |gnt ? holdCnt + 16'd1 : '0;
      gapCnt <= (state == GAP) ? gapCnt + 4'd1 : '0;
      // a requester that times out stays locked until it lowers its request
      lock <= (lock | (timeout ? gnt : 3'b000)) & req;
      rrLastDc <= nextGnt[2] | (rrLastDc & ~nextGnt[1]);
    end
  end
  assign {directCntlGnt, sendPacketGnt, sofGnt} = gnt;
  assign busy = state != IDLE;
  assign txPortRdyOut = txPortRdyIn;
  assign txPortWEnable = |(gnt & {directCntlWEn, sendPacketWEn, sofWEn});
  assign txPortData = ({8{gnt[0]}} & sofData) | ({8{gnt[1]}} & sendPacketData) |
                      ({8{gnt[2]}} & directCntlData);
  assign txPortCntl = ({8{gnt[0]}} & sofCntl) | ({8{gnt[1]}} & sendPacketCntl) |
                      ({8{gnt[2]}} & directCntlCntl);
endmodule

// File: tb/tb_tx_port_scheduler.sv
// tb_tx_port_scheduler: two schedulers (gap 2 and gap 0, hold limit 4) driven in parallel and
// compared every cycle against a requester-level model, plus directed literal scenarios.
module tb_tx_port_scheduler;
  localparam int HM [2] = '{4, 4};
  localparam int GC [2] = '{2, 0};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdyIn = 1'b0;
  logic [2:0] req = '0, wen = '0;
  logic [2:0][7:0] dat = '0, cnt = '0;
  logic [1:0][2:0] dGnt;
  logic [1:0][7:0] dData, dCntl;
  logic [1:0] dBusy, dTerr, dWe, dRdy;
  int passCnt = 0, total = 0;
  bit chk = 1'b0;
  int mG [2] = '{-1, -1};
  int mHeld [2] = '{0, 0};
  int mGap [2] = '{0, 0};
  logic [2:0] mLock [2] = '{3'b0, 3'b0};
  bit mLastDc [2] = '{1'b1, 1'b1};
  bit mTerr [2] = '{1'b0, 1'b0};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : dut
    tx_port_scheduler #(.HOLD_MAX(HM[g]), .GAP_CYCLES(GC[g])) u (
      .clk(clk), .rst(rst),
      .sofReq(req[0]), .sendPacketReq(req[1]), .directCntlReq(req[2]),
      .sofWEn(wen[0]), .sendPacketWEn(wen[1]), .directCntlWEn(wen[2]),
      .sofData(dat[0]), .sendPacketData(dat[1]), .directCntlData(dat[2]),
      .sofCntl(cnt[0]), .sendPacketCntl(cnt[1]), .directCntlCntl(cnt[2]),
      .sofGnt(dGnt[g][0]), .sendPacketGnt(dGnt[g][1]), .directCntlGnt(dGnt[g][2]),
      .txPortRdyIn(rdyIn), .txPortRdyOut(dRdy[g]), .txPortWEnable(dWe[g]),
      .txPortData(dData[g]), .txPortCntl(dCntl[g]),
      .timeoutErr(dTerr[g]), .busy(dBusy[g]));
  end
  task automatic check(string nm, int act, int exp);
    total++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // requester-level model: who holds the port, for how long, and how much gap remains
  task automatic modelStep(int k);
    logic [2:0] e;
    if (!rst) begin
      mG[k] = -1; mHeld[k] = 0; mGap[k] = 0; mLock[k] = '0; mLastDc[k] = 1'b1; mTerr[k] = 1'b0;
      return;
    end
    mTerr[k] = 1'b0;
    if (mG[k] >= 0) begin
      mHeld[k]++;
      if (!req[mG[k]] || mHeld[k] == HM[k]) begin
        if (req[mG[k]]) begin
          mTerr[k] = 1'b1;
          mLock[k][mG[k]] = 1'b1;
        end
        mG[k] = -1;
        mGap[k] = GC[k];
      end
    end else if (mGap[k] > 0) mGap[k]--;
    else begin
      e = req & ~mLock[k];
      if (e[0]) mG[k] = 0;
      else if (e[1] && e[2]) mG[k] = mLastDc[k] ? 1 : 2;
      else if (e[1]) mG[k] = 1;
      else if (e[2]) mG[k] = 2;
      if (mG[k] == 1) mLastDc[k] = 1'b0;
      if (mG[k] == 2) mLastDc[k] = 1'b1;
      mHeld[k] = 0;
    end
    mLock[k] &= req;
  endtask
  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
  end
  always @(negedge clk) begin
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        logic [2:0] eg;
        logic [7:0] ed, ec;
        eg = (mG[k] >= 0) ? 3'(1 << mG[k]) : 3'b000;
        ed = '0;
        ec = '0;
        for (int j = 0; j < 3; j++) if (eg[j]) begin ed = dat[j]; ec = cnt[j]; end
        check($sformatf("gnt%0d", k), int'(dGnt[k]), int'(eg));
        check($sformatf("oneHot%0d", k), int'($countones(dGnt[k]) <= 1), 1);
        check($sformatf("busy%0d", k), int'(dBusy[k]), int'(mG[k] >= 0 || mGap[k] > 0));
        check($sformatf("timeoutErr%0d", k), int'(dTerr[k]), int'(mTerr[k]));
        check($sformatf("txPort%0d", k), int'({dWe[k], dData[k], dCntl[k], dRdy[k]}),
              int'({|(eg & wen), ed, ec, rdyIn}));
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic doReset(logic [2:0] r);
    rst = 1'b0;
    req = r;
    step();
    rst = 1'b1;
  endtask
  initial begin
    int order[$];
    int hc [3];
    int n, idleRun, gapObs, gCnt, tCnt;
    logic [2:0] g, prevG;
    doReset(3'b000);
    chk = 1'b1;
    // SP and DC both requesting from reset release, each dropping after 3 granted cycles
    doReset(3'b110);
    prevG = '0; idleRun = 0; gapObs = -1; hc = '{0, 0, 0};
    for (int i = 0; i < 30; i++) begin
      step(); #1;
      g = dGnt[0];
      if (g != 0 && prevG == 0) begin
        order.push_back(int'(g));
        if (order.size() == 2) gapObs = idleRun;
      end
      idleRun = (g == 0) ? idleRun + 1 : 0;
      for (int j = 1; j < 3; j++)
        if (g[j]) begin
          hc[j]++;
          if (hc[j] == 3) begin req[j] = 1'b0; hc[j] = 0; end
        end else req[j] = 1'b1;
      prevG = g;
    end
    check("rrFirst", order.size() > 0 ? order[0] : 0, 3'b010);
    check("rrSecond", order.size() > 1 ? order[1] : 0, 3'b100);
    check("rrThird", order.size() > 2 ? order[2] : 0, 3'b010);
    check("interGrantIdle", gapObs, 3);
    // SOF beats SP arriving in the same IDLE cycle; SP follows after gap and idle
    doReset(3'b000);
    step();
    req = 3'b011;
    step(); #1;
    check("sofFirst", int'(dGnt[0]), 3'b001);
    step(); step();
    req[0] = 1'b0;
    step(); #1;
    check("sofRelease", int'(dGnt[0]), 0);
    n = 0;
    while (dGnt[0][1] == 1'b0 && n < 10) begin step(); #1; n++; end
    check("spAfterSof", n, 3);
    // hold limit of 4 with DC held high, then lockout until DC drops and returns
    doReset(3'b100);
    gCnt = 0; tCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      gCnt += int'(dGnt[0][2]);
      tCnt += int'(dTerr[0]);
    end
    check("holdCycles", gCnt, 4);
    check("timeoutPulses", tCnt, 1);
    req = 3'b000;
    step(); #1;
    req = 3'b100;
    n = 0;
    while (dGnt[0][2] == 1'b0 && n < 10) begin step(); #1; n++; end
    check("regrantAfterDrop", n, 1);
    // muxed TX drive while SP is granted, and zero after release
    doReset(3'b010);
    wen = 3'b010; dat[1] = 8'hA5; cnt[1] = 8'h3C;
    step(); #1;
    check("spDrive", int'({dWe[0], dData[0], dCntl[0]}), int'({1'b1, 8'hA5, 8'h3C}));
    req = 3'b000;
    step(); #1;
    check("spDriveOff", int'({dWe[0], dData[0], dCntl[0]}), 0);
    // reset during a SOF grant, then release with SOF still requesting
    doReset(3'b001);
    step(); #1;
    check("sofGranted", int'(dGnt[0][0]), 1);
    rst = 1'b0;
    step(); #1;
    check("resetDropsGnt", int'({dGnt[0][0], dBusy[0]}), 0);
    rst = 1'b1;
    step(); #1;
    check("sofAfterReset", int'(dGnt[0][0]), 1);
    // zero-gap instance hands directly to DC after SP releases
    doReset(3'b010);
    step(); step();
    req = 3'b100;
    step(); #1;
    check("gap0Release", int'(dGnt[1]), 0);
    step(); #1;
    check("gap0DcGrant", int'(dGnt[1]), 3'b100);
    // random traffic with occasional resets
    req = '0;
    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < 3; j++) if ($urandom_range(0, 5) == 0) req[j] = ~req[j];
      wen = 3'($urandom);
      dat = 24'($urandom);
      cnt = 24'($urandom);
      rdyIn = 1'($urandom);
      rst = ($urandom_range(0, 99) != 0);
      step();
    end
    @(posedge clk); #1;
    chk = 1'b0;
    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule
